// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic engine: op codes, FSM
// states, iterative-unit mode and signed MIN/MAX helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package calc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_MOD  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } calc_state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    // Helpers return a wide vector; callers keep the low WIDTH bits.
    localparam int CALC_MAX_W = 128;

    function automatic logic [CALC_MAX_W-1:0] calc_max(input int w);
        return (CALC_MAX_W'(1) << (w - 1)) - CALC_MAX_W'(1);
    endfunction

    function automatic logic [CALC_MAX_W-1:0] calc_min(input int w);
        return CALC_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/calc_seq_muldiv.sv
// Unsigned iterative shift-add multiplier / restoring divider on magnitudes.
// Latency: first step on the go edge, ready in the WIDTH-th cycle after go.
// Backpressure: none; go restarts the unit, clear aborts it.
// Ports: go/mode/a_mag/b_mag start an operation (MUL: a*b, DIV: a/b);
//        ready high when idle or finished; product, quotient, remainder out.
module calc_seq_muldiv
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               go,
    input  md_mode_e           mode,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               ready,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    md_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] dv_q, dv_d, hi_q, hi_d, lo_q, lo_d;

    md_mode_e         src_mode;
    logic [WIDTH-1:0] src_dv, src_hi, src_lo, step_hi, step_lo, diff;
    logic [WIDTH:0]   sum, trial;
    logic             ge;

    // One step per cycle. On go the step runs on the fresh operands so the
    // final step lands in cycle WIDTH-1 after go and the engine can register
    // the answer on the following edge.
    // MUL: hi:lo holds partial product : remaining multiplier bits (LSB first).
    // DIV: hi:lo holds partial remainder : dividend bits shifting into quotient.
    always_comb begin
        src_mode = go ? mode : mode_q;
        src_hi   = go ? '0 : hi_q;
        if (go) begin
            src_lo = (mode == MD_MUL) ? b_mag : a_mag;
            src_dv = (mode == MD_MUL) ? a_mag : b_mag;
        end else begin
            src_lo = lo_q;
            src_dv = dv_q;
        end

        sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_dv} : '0);
        trial = {src_hi, src_lo[WIDTH-1]};
        ge    = (trial >= {1'b0, src_dv});
        // Only used when ge: the true difference is below the divisor.
        diff  = trial[WIDTH-1:0] - src_dv;

        if (src_mode == MD_MUL) begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], src_lo[WIDTH-1:1]};
        end else begin
            step_hi = ge ? diff : trial[WIDTH-1:0];
            step_lo = {src_lo[WIDTH-2:0], ge};
        end

        cnt_d  = cnt_q;
        mode_d = mode_q;
        dv_d   = dv_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (clear) begin
            cnt_d  = '0;
            mode_d = MD_MUL;
            dv_d   = '0;
            hi_d   = '0;
            lo_d   = '0;
        end else if (go) begin
            cnt_d  = CW'(WIDTH - 1);
            mode_d = mode;
            dv_d   = src_dv;
            hi_d   = step_hi;
            lo_d   = step_lo;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            hi_d   = step_hi;
            lo_d   = step_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            mode_q <= MD_MUL;
            dv_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dv_q   <= dv_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign ready     = (cnt_q == '0);
    assign product   = {hi_q, lo_q};
    assign quotient  = lo_q;
    assign remainder = hi_q;

endmodule

// File: rtl/calc_arith_engine.sv
// Multi-cycle signed ADD/SUB/MUL/DIV/MOD/PASS core with optional saturation.
// Latency: done 2 cycles after start for 1-cycle ops, WIDTH+1 for MUL/DIV/MOD.
// Backpressure: start/loads ignored unless IDLE; no queueing.
// Ports: in_data/load_a/load_b fill operands; op+start launch; busy/done
//        handshake; result with ovf/dz/err flags held until next start.
module calc_arith_engine
    import calc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             dz,
    output logic             err
);

    localparam logic [CALC_MAX_W-1:0] MAX_FULL = calc_max(WIDTH);
    localparam logic [CALC_MAX_W-1:0] MIN_FULL = calc_min(WIDTH);
    localparam logic [WIDTH-1:0]      MAX_V    = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]      MIN_V    = MIN_FULL[WIDTH-1:0];

    calc_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       opc_q, opc_d;
    logic             ovf_q, ovf_d, dz_q, dz_d, err_q, err_d;

    logic               accept, md_go, md_ready, md_wait;
    md_mode_e           md_mode;
    logic [WIDTH-1:0]   a_mag, b_mag, quotient, remainder;
    logic [2*WIDTH-1:0] product;

    // The iterative unit is kicked on the accepting edge itself using the
    // pre-load register values, so a load in the start cycle never leaks in.
    always_comb begin
        accept  = (state_q == ST_IDLE) && start && !clear;
        md_go   = accept && ((op == OP_MUL) ||
                  (((op == OP_DIV) || (op == OP_MOD)) && (b_q != '0)));
        md_mode = (op == OP_MUL) ? MD_MUL : MD_DIV;
        a_mag   = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag   = b_q[WIDTH-1] ? -b_q : b_q;
    end

    calc_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .go        (md_go),
        .mode      (md_mode),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .ready     (md_ready),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    logic               neg, mul_ovf, div_ovf, ovf_calc, dz_calc, err_calc;
    logic [WIDTH:0]     add_s, sub_s, prod_top;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, res_calc;

    // Sign fix-up, overflow and saturation on the latched operands.
    always_comb begin
        neg      = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
        add_s    = {opa_q[WIDTH-1], opa_q} + {opb_q[WIDTH-1], opb_q};
        sub_s    = {opa_q[WIDTH-1], opa_q} - {opb_q[WIDTH-1], opb_q};
        prod_s   = neg ? -product : product;
        // Representable iff the top WIDTH+1 bits are a pure sign extension.
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        mul_ovf  = !((&prod_top) || !(|prod_top));
        quo_s    = neg ? -quotient : quotient;
        // A positive quotient with the MSB set only arises from MIN / -1.
        div_ovf  = !neg && quotient[WIDTH-1];
        rem_s    = opa_q[WIDTH-1] ? -remainder : remainder;
        md_wait  = (opc_q == OP_MUL) ||
                   (((opc_q == OP_DIV) || (opc_q == OP_MOD)) && (opb_q != '0));

        res_calc = '0;
        ovf_calc = 1'b0;
        dz_calc  = 1'b0;
        err_calc = 1'b0;
        case (opc_q)
            OP_ADD: begin
                ovf_calc = add_s[WIDTH] ^ add_s[WIDTH-1];
                res_calc = (ovf_calc && SATURATE) ?
                           (add_s[WIDTH] ? MIN_V : MAX_V) : add_s[WIDTH-1:0];
            end
            OP_SUB: begin
                ovf_calc = sub_s[WIDTH] ^ sub_s[WIDTH-1];
                res_calc = (ovf_calc && SATURATE) ?
                           (sub_s[WIDTH] ? MIN_V : MAX_V) : sub_s[WIDTH-1:0];
            end
            OP_MUL: begin
                ovf_calc = mul_ovf;
                res_calc = (mul_ovf && SATURATE) ?
                           (neg ? MIN_V : MAX_V) : prod_s[WIDTH-1:0];
            end
            OP_DIV: begin
                if (opb_q == '0) begin
                    dz_calc = 1'b1;
                end else begin
                    ovf_calc = div_ovf;
                    res_calc = (div_ovf && SATURATE) ? MAX_V : quo_s;
                end
            end
            OP_MOD: begin
                if (opb_q == '0) begin
                    dz_calc = 1'b1;
                end else begin
                    res_calc = rem_s;
                end
            end
            OP_PASS: res_calc = opa_q;
            default: err_calc = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        opc_d    = opc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (load_a) a_d = in_data;
                if (load_b) b_d = in_data;
                if (start) begin
                    opa_d   = a_q;
                    opb_d   = b_q;
                    opc_d   = op;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!md_wait || md_ready) begin
                    result_d = res_calc;
                    ovf_d    = ovf_calc;
                    dz_d     = dz_calc;
                    err_d    = err_calc;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d  = ST_IDLE;
            a_d      = '0;
            b_d      = '0;
            opa_d    = '0;
            opb_d    = '0;
            opc_d    = '0;
            result_d = '0;
            ovf_d    = 1'b0;
            dz_d     = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            opc_q    <= opc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == ST_EXEC);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
    assign dz     = dz_q;
    assign err    = err_q;

endmodule
